// File: rtl/rand_word_sched.sv
// ============================================================================
// Module      : rand_word_sched
// Description : Round-robin scheduler that assembles a WIDTH-bit random word
//               from a shared serial bit generator for one requester at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rand_word_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic             ack_i,
    input  logic             lfsr_bit_i,
    output logic             lfsr_en_o,
    output logic [NREQ-1:0]  gnt_o,
    output logic [WIDTH-1:0] rand_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand;
    logic             found;
    // The final bit goes straight into rand_o, so only WIDTH-1 bits are staged.
    logic [WIDTH-2:0] shift;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] word_next;

    assign word_next = {shift, lfsr_bit_i};
    assign lfsr_en_o = (state == FILL);
    assign busy_o    = (state != IDLE);

    // Round-robin search starting one above the last served index.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            gnt_o   <= '0;
            valid_o <= 1'b0;
            rand_o  <= '0;
            shift   <= '0;
            count   <= '0;
            gidx    <= '0;
            ptr     <= PW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= FILL;
                        gnt_o <= NREQ'(1) << pick_idx;
                        gidx  <= pick_idx;
                        count <= '0;
                        shift <= '0;
                    end
                end
                FILL: begin
                    if ((req_i & gnt_o) == '0) begin
                        state <= IDLE;
                        gnt_o <= '0;
                        ptr   <= gidx;
                        shift <= '0;
                        count <= '0;
                    end else begin
                        shift <= word_next[WIDTH-2:0];
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state   <= DELIVER;
                            rand_o  <= word_next;
                            valid_o <= 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    // A dropped request does not discard the word; only ack ends it.
                    if (ack_i) begin
                        state   <= IDLE;
                        gnt_o   <= '0;
                        valid_o <= 1'b0;
                        ptr     <= gidx;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rand_word_sched.sv
// ============================================================================
// Module      : tb_rand_word_sched
// Description : Directed scoreboard bench for rand_word_sched (NREQ=4, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rand_word_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NREQ-1:0]  req_i;
    logic             ack_i;
    logic             lfsr_bit_i;
    logic             lfsr_en_o;
    logic [NREQ-1:0]  gnt_o;
    logic [WIDTH-1:0] rand_o;
    logic             valid_o;
    logic             busy_o;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_word;

    rand_word_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .lfsr_bit_i (lfsr_bit_i),
        .lfsr_en_o  (lfsr_en_o),
        .gnt_o      (gnt_o),
        .rand_o     (rand_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Grant, fill WIDTH bits, optionally stall in DELIVER, then acknowledge.
    task automatic run_txn(input logic [NREQ-1:0] req, input logic [NREQ-1:0] exp_gnt,
                           input logic [WIDTH-1:0] w, input int stall,
                           input bit toggle, input bit ack_in_fill);
        logic [WIDTH-1:0] model;
        logic [WIDTH-1:0] exp;
        int               en_cycles;
        model     = '0;
        en_cycles = 0;
        req_i = req;
        step();
        chk("grant", gnt_o, exp_gnt);
        chk("busy_fill", busy_o, 1);
        ack_i = ack_in_fill;
        for (int k = 0; k < WIDTH; k++) begin
            lfsr_bit_i = w[WIDTH-1-k];
            model      = {model[WIDTH-2:0], lfsr_bit_i};
            chk("valid_in_fill", valid_o, 0);
            if (lfsr_en_o === 1'b1) en_cycles++;
            step();
        end
        ack_i = 1'b0;
        exp_q.push_back(model);
        // valid_o rises on the WIDTH-th edge after the grant edge (WIDTH+1 edges inclusive).
        chk("lfsr_en_cycles", en_cycles, WIDTH);
        chk("valid_rise", valid_o, 1);
        chk("lfsr_en_deliver", lfsr_en_o, 0);
        exp = exp_q.pop_front();
        chk("rand_word", rand_o, exp);
        chk("gnt_deliver", gnt_o, exp_gnt);
        for (int s = 0; s < stall; s++) begin
            if (toggle) req_i = NREQ'($urandom);
            step();
            chk("stall_rand", rand_o, exp);
            chk("stall_gnt", gnt_o, exp_gnt);
            chk("stall_valid", valid_o, 1);
            chk("stall_en", lfsr_en_o, 0);
        end
        req_i = req;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        chk("ack_gnt", gnt_o, 0);
        chk("ack_valid", valid_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("rand_hold", rand_o, exp);
        last_word = exp;
    endtask

    initial begin
        rst_i      = 1'b0;
        req_i      = '0;
        ack_i      = 1'b0;
        lfsr_bit_i = 1'b0;
        last_word  = '0;
        step();
        step();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_en", lfsr_en_o, 0);
        chk("rst_rand", rand_o, 0);

        rst_i = 1'b1;
        step();
        step();
        chk("idle_gnt", gnt_o, 0);
        chk("idle_en", lfsr_en_o, 0);
        chk("idle_busy0", busy_o, 0);

        // Round-robin with all requests held; ack during FILL must be ignored.
        run_txn(4'b1111, 4'b0001, 8'h5A, 0, 0, 0);
        run_txn(4'b1111, 4'b0010, 8'hC3, 0, 0, 0);
        run_txn(4'b1111, 4'b0100, 8'h96, 0, 0, 1);
        run_txn(4'b1111, 4'b1000, 8'h0F, 0, 0, 0);
        run_txn(4'b1111, 4'b0001, 8'hF0, 0, 0, 0);
        req_i = '0;
        step();

        // Single request with bits 1,1,0,1,0,0,0,1 and a 20-cycle stall.
        run_txn(4'b0001, 4'b0001, 8'hD1, 20, 1, 0);
        chk("d1_hold", rand_o, 8'hD1);
        req_i = '0;
        step();

        // Abort after three FILL cycles.
        req_i = 4'b0100;
        step();
        chk("abort_grant", gnt_o, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            lfsr_bit_i = 1'b1;
            step();
        end
        chk("abort_pre_en", lfsr_en_o, 1);
        req_i = '0;
        step();
        chk("abort_en", lfsr_en_o, 0);
        chk("abort_gnt", gnt_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_rand", rand_o, last_word);
        run_txn(4'b0101, 4'b0001, 8'h3C, 0, 0, 0);
        req_i = '0;
        step();

        // Reset pulsed during FILL cycle 5.
        req_i = 4'b0010;
        step();
        chk("mrst_grant", gnt_o, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            lfsr_bit_i = k[0];
            step();
        end
        rst_i = 1'b0;
        #1;
        chk("mrst_gnt", gnt_o, 0);
        chk("mrst_en", lfsr_en_o, 0);
        chk("mrst_valid", valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_rand", rand_o, 0);
        req_i = '0;
        step();
        step();
        rst_i = 1'b1;
        run_txn(4'b1000, 4'b1000, 8'hA7, 0, 0, 0);
        req_i = '0;
        step();

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/rand_word_sched.md
RAND_WORD_SCHED -- requirements
Module: rand_word_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the random word width in bits (2..16).
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port req_i, input, NREQ bits, SHALL carry level requests, one bit per requester.
REQ-006 Port ack_i, input, 1 bit, SHALL be the granted requester's acknowledgement of a delivered word.
REQ-007 Port lfsr_bit_i, input, 1 bit, SHALL be the serial random bit from the shared bit generator.
REQ-008 Port lfsr_en_o, output, 1 bit, SHALL be the advance-enable to the shared bit generator.
REQ-009 Port gnt_o, output, NREQ bits, SHALL be the one-hot grant, or zero when no grant is held.
REQ-010 Port rand_o, output, WIDTH bits, SHALL be the assembled random word.
REQ-011 Port valid_o, output, 1 bit, SHALL mean rand_o is complete for the requester in gnt_o.
REQ-012 Port busy_o, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, FILL and DELIVER.
REQ-014 In IDLE with req_i nonzero, the block SHALL grant round-robin, searching upward from index ptr+1 mod NREQ, and enter FILL on the same edge with gnt_o registered one-hot.
REQ-015 In IDLE with req_i zero, the block SHALL hold state, with gnt_o = 0 and lfsr_en_o = 0.
REQ-016 lfsr_en_o SHALL be high in FILL only; it is a decode of state and is never high in IDLE or DELIVER.
REQ-017 Each FILL cycle SHALL apply shift <= {shift[WIDTH-2:0], lfsr_bit_i}: first bit received ends in the MSB, bit count +1.
REQ-018 FILL SHALL last exactly WIDTH cycles; on the edge completing the WIDTH-th bit, the block SHALL enter DELIVER.
REQ-019 On entering DELIVER, rand_o SHALL show the full word and valid_o SHALL go high.
REQ-020 Latency SHALL be WIDTH+1 edges from the grant edge to valid_o high.
REQ-021 rand_o SHALL hold its last delivered value outside DELIVER; the shift register SHALL be internal.
REQ-022 In DELIVER, valid_o, rand_o and gnt_o SHALL hold stable until ack_i=1 is sampled.
REQ-023 On ack_i=1 in DELIVER, the block SHALL update ptr to the granted index, clear gnt_o and valid_o, and return to IDLE.
REQ-024 A new grant SHALL not be issued before one IDLE cycle has elapsed.
REQ-025 ack_i SHALL be ignored outside DELIVER.
REQ-026 If the granted req_i bit falls during FILL, the block SHALL abort on the next edge and return to IDLE with the partial word discarded.
REQ-027 On such an abort, gnt_o SHALL clear, valid_o SHALL never assert, rand_o SHALL be unchanged, and ptr SHALL update to the aborted index.
REQ-028 If the granted req_i bit falls during DELIVER, the block SHALL still wait for ack_i; the word is not dropped.
REQ-029 Requests from other requesters during FILL or DELIVER SHALL have no effect until IDLE.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL clear on every entry to FILL.

Reset
REQ-031 While rst_i=0, regardless of clock, the block SHALL force state=IDLE, gnt_o=0, valid_o=0, busy_o=0, lfsr_en_o=0, rand_o=0, shift=0, count=0 and ptr=NREQ-1, so that requester 0 is first priority.
REQ-032 Reset asserted in FILL or DELIVER SHALL abandon the transaction with no valid_o pulse.
REQ-033 After rst_i is released, the first grant SHALL occur on the first rising edge with req_i nonzero.

Verification
REQ-034 Single request (NREQ=4, WIDTH=8): req_i=0001 and lfsr_bit_i sequence 1,1,0,1,0,0,0,1 -> gnt_o=0001, lfsr_en_o high exactly 8 cycles, valid_o high 9 edges after grant, rand_o=8'hD1, held until ack_i.
REQ-035 Round-robin: req_i=1111 held, ack_i issued on each valid_o -> gnt_o order 0001, 0010, 0100, 1000, 0001; each grant has one IDLE cycle between.
REQ-036 Abort: req_i[2] granted, then dropped after 3 FILL cycles -> lfsr_en_o drops on the next edge, no valid_o, rand_o unchanged, next grant from req_i=0101 goes to index 0.
REQ-037 Stall: valid_o high, ack_i held 0 for 20 cycles while req_i toggles -> rand_o and gnt_o stable and lfsr_en_o=0 throughout.
REQ-038 Mid-operation reset: rst_i pulsed low during FILL cycle 5 -> all outputs immediately 0; after release, req_i=1000 is granted to index 3 and completes with a full 8-cycle FILL.
